dmem_arbiter: RTL

Two-port arbiter that shares the single data-memory port (the LSU/dmem path at base 0x1000_0000) between the pipeline's load/store unit (core port) and a debug/program-loader master (debug port). One transfer per cycle. The core has default priority, and a starvation counter bounds how long the debug port can wait. The debug port can lock the memory for bursts. Read data returns one cycle after grant and is steered back to the requester that issued the read.

---
 rtl/dmem_arb_pkg.sv | 19 +
 rtl/dmem_arbiter.sv | 105 ++++++++++
 2 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM states, LSU access codes
// and the data-memory base address.
package dmem_arb_pkg;

    typedef enum logic {ARB, LOCK} arb_state_e;

    // Loads and stores share funct3-style codes; direction comes from wren.
    localparam logic [2:0] LSU_LB  = 3'b000;
    localparam logic [2:0] LSU_LH  = 3'b001;
    localparam logic [2:0] LSU_LW  = 3'b010;
    localparam logic [2:0] LSU_LBU = 3'b100;
    localparam logic [2:0] LSU_LHU = 3'b101;
    localparam logic [2:0] LSU_SB  = 3'b000;
    localparam logic [2:0] LSU_SH  = 3'b001;
    localparam logic [2:0] LSU_SW  = 3'b010;

    localparam logic [31:0] DMEM_BASE = 32'h1000_0000;

endpackage

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the core LSU and a debug master.
// Core has default priority; a starvation counter bounds debug wait; debug may lock.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_c_req,
    input  logic [31:0] i_c_addr,
    input  logic [31:0] i_c_wdata,
    input  logic        i_c_wren,
    input  logic [2:0]  i_c_ctrl,
    output logic        o_c_gnt,
    output logic        o_c_stall,
    output logic        o_c_rvalid,
    output logic [31:0] o_c_rdata,
    input  logic        i_d_req,
    input  logic [31:0] i_d_addr,
    input  logic [31:0] i_d_wdata,
    input  logic        i_d_wren,
    input  logic [2:0]  i_d_ctrl,
    input  logic        i_d_lock,
    output logic        o_d_gnt,
    output logic        o_d_rvalid,
    output logic [31:0] o_d_rdata,
    output logic [31:0] o_m_addr,
    output logic [31:0] o_m_wdata,
    output logic [2:0]  o_m_ctrl,
    output logic        o_m_wren,
    input  logic [31:0] i_m_rdata
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    arb_state_e    state_q, state_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          rd_pend_q, rd_pend_d;
    logic          rd_owner_q, rd_owner_d;   // 1 = debug issued the pending read
    logic          c_win, d_win;

    always_comb begin
        c_win = 1'b0;
        d_win = 1'b0;
        if (state_q == LOCK) begin
            d_win = i_d_req;
        end else if (i_d_req && (starve_q == STARVE_LIM || !i_c_req)) begin
            d_win = 1'b1;
        end else begin
            c_win = i_c_req;
        end
    end

    always_comb begin
        o_c_gnt   = c_win;
        o_d_gnt   = d_win;
        o_c_stall = i_c_req & ~c_win;
        o_m_addr  = d_win ? i_d_addr  : i_c_addr;
        o_m_wdata = d_win ? i_d_wdata : i_c_wdata;
        o_m_ctrl  = d_win ? i_d_ctrl  : i_c_ctrl;
        o_m_wren  = (d_win & i_d_wren) | (c_win & i_c_wren);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:     if (d_win && i_d_lock) state_d = LOCK;
            LOCK:    if (!i_d_lock)         state_d = ARB;
            default: state_d = ARB;
        endcase

        starve_d = '0;
        if (i_d_req && !d_win) begin
            starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 1'b1;
        end

        rd_pend_d  = (c_win & ~i_c_wren) | (d_win & ~i_d_wren);
        rd_owner_d = d_win;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ARB;
            starve_q   <= '0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // Memory returns data one cycle after the address; steer it by the saved owner.
    always_comb begin
        o_c_rvalid = rd_pend_q & ~rd_owner_q;
        o_d_rvalid = rd_pend_q &  rd_owner_q;
        o_c_rdata  = o_c_rvalid ? i_m_rdata : 32'h0;
        o_d_rdata  = o_d_rvalid ? i_m_rdata : 32'h0;
    end

endmodule
